// File: rtl/ant_step_scheduler_pkg.sv
// Shared parameters and state encoding for the ant step scheduler and its round-robin search.
package ant_step_scheduler_pkg;

    localparam int ANT_num = 8;
    localparam int X_bits  = 8;
    localparam int Y_bits  = 7;

    typedef enum logic [2:0] {
        IDLE,
        COMPUTE,
        SETTLE,
        WRITE,
        MOVE,
        DONE
    } sched_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ant_next_alive.sv
// Round-robin search for the next set bit of a mask, starting at (or just after) a base index.
module ant_next_alive #(
    parameter int N        = 8,
    parameter int IDX_BITS = 3
) (
    input  logic [N-1:0]        mask,
    input  logic [IDX_BITS-1:0] base,
    input  logic                include_base,
    output logic                found,
    output logic [IDX_BITS-1:0] idx
);

    int                  pos;
    logic [IDX_BITS-1:0] pos_i;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        pos_i = '0;
        for (int k = 0; k < N; k++) begin
            // base < N and the offset is at most N, so one subtraction wraps it
            pos = int'(base) + k + (include_base ? 0 : 1);
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_i = IDX_BITS'(pos);
            if (!found && mask[pos_i]) begin
                found = 1'b1;
                idx   = pos_i;
            end
        end
    end

endmodule

// File: rtl/ant_step_scheduler.sv
// Sequences one ant-array step: newLocClock pulse, settle wait, then one world write per live ant.
// Optional macro ANT_SCHED_ROTATE_EN rotates the first-write priority by one ant per step.
//
// state   | meaning
// IDLE    | waiting for step_req (blocked in setup_mode)
// COMPUTE | new_loc_clk pulse, settle counter loaded
// SETTLE  | waiting for ant logic to settle
// WRITE   | wr_valid to world memory for ant cur
// MOVE    | move_now pulse for ant cur, pick next live ant
// DONE    | step_done pulse, step_count increment
module ant_step_scheduler
    import ant_step_scheduler_pkg::*;
#(
    parameter int ANT_NUM       = ANT_num,
    parameter int X_BITS        = X_bits,
    parameter int Y_BITS        = Y_bits,
    parameter int SETTLE_CYCLES = 4,
    parameter int IDX_BITS      = idx_width(ANT_NUM)
) (
    input  logic                      Clk,
    input  logic                      Reset_N,
    input  logic                      setup_mode,
    input  logic                      step_req,
    input  logic [ANT_NUM-1:0]        alive_mask,
    input  logic [ANT_NUM*X_BITS-1:0] ant_x,
    input  logic [ANT_NUM*Y_BITS-1:0] ant_y,
    input  logic [ANT_NUM-1:0]        ant_sugar,
    input  logic                      wr_ready,
    output logic                      new_loc_clk,
    output logic                      global_writing_flag,
    output logic                      wr_valid,
    output logic [X_BITS-1:0]         wr_x,
    output logic [Y_BITS-1:0]         wr_y,
    output logic                      wr_sugar,
    output logic [ANT_NUM-1:0]        move_now,
    output logic                      busy,
    output logic                      step_done,
    output logic [15:0]               step_count
);

    sched_state_t        state_q, state_d;
    logic [7:0]          settle_cnt_q;
    logic [IDX_BITS-1:0] cur_q;
    logic [ANT_NUM-1:0]  pending_q;
    logic [X_BITS-1:0]   wr_x_q;
    logic [Y_BITS-1:0]   wr_y_q;
    logic                wr_sugar_q;
    logic [15:0]         step_count_q;
    logic [IDX_BITS-1:0] start_ptr;
    logic [ANT_NUM-1:0]  cur_onehot;
    logic                abort;

    logic [ANT_NUM-1:0]  srch_mask;
    logic [IDX_BITS-1:0] srch_base;
    logic                srch_incl;
    logic                srch_found;
    logic [IDX_BITS-1:0] srch_idx;

    logic [X_BITS-1:0]   x_arr [ANT_NUM];
    logic [Y_BITS-1:0]   y_arr [ANT_NUM];

    always_comb begin
        for (int i = 0; i < ANT_NUM; i++) begin
            x_arr[i] = ant_x[i*X_BITS +: X_BITS];
            y_arr[i] = ant_y[i*Y_BITS +: Y_BITS];
        end
    end

    assign cur_onehot = ANT_NUM'(1) << cur_q;
    assign abort      = setup_mode && (state_q != IDLE);

    // SETTLE scans the live mask from the start pointer; MOVE scans what is still pending after cur
    assign srch_mask = (state_q == SETTLE) ? alive_mask : pending_q;
    assign srch_base = (state_q == SETTLE) ? start_ptr : cur_q;
    assign srch_incl = (state_q == SETTLE);

    ant_next_alive #(
        .N        (ANT_NUM),
        .IDX_BITS (IDX_BITS)
    ) u_next_alive (
        .mask         (srch_mask),
        .base         (srch_base),
        .include_base (srch_incl),
        .found        (srch_found),
        .idx          (srch_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (step_req && !setup_mode) state_d = COMPUTE;
            COMPUTE: state_d = SETTLE;
            SETTLE:  if (settle_cnt_q <= 8'd1) state_d = srch_found ? WRITE : DONE;
            WRITE:   if (wr_ready) state_d = MOVE;
            MOVE:    state_d = srch_found ? WRITE : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        new_loc_clk         = (state_q == COMPUTE);
        wr_valid            = (state_q == WRITE);
        global_writing_flag = (state_q == WRITE) || (state_q == MOVE);
        move_now            = (state_q == MOVE) ? cur_onehot : '0;
        busy                = (state_q != IDLE);
        step_done           = (state_q == DONE) && !setup_mode;
        wr_x                = wr_x_q;
        wr_y                = wr_y_q;
        wr_sugar            = wr_sugar_q;
        step_count          = step_count_q;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            cur_q        <= '0;
            pending_q    <= '0;
            wr_x_q       <= '0;
            wr_y_q       <= '0;
            wr_sugar_q   <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == COMPUTE) begin
                settle_cnt_q <= 8'(SETTLE_CYCLES);
            end else if (state_q == SETTLE && settle_cnt_q != 8'd0) begin
                settle_cnt_q <= settle_cnt_q - 8'd1;
            end
            if (state_d == WRITE && state_q != WRITE) begin
                cur_q      <= srch_idx;
                wr_x_q     <= x_arr[srch_idx];
                wr_y_q     <= y_arr[srch_idx];
                wr_sugar_q <= ant_sugar[srch_idx];
                if (state_q == SETTLE) begin
                    pending_q <= alive_mask;
                end
            end
            if (state_q == WRITE && wr_ready) begin
                pending_q <= pending_q & ~cur_onehot;
            end
            if (step_done) begin
                step_count_q <= step_count_q + 16'd1;
            end
            // setup_mode drops the step on the floor and leaves the write port quiet
            if (abort) begin
                cur_q      <= '0;
                pending_q  <= '0;
                wr_x_q     <= '0;
                wr_y_q     <= '0;
                wr_sugar_q <= 1'b0;
            end
        end
    end

`ifdef ANT_SCHED_ROTATE_EN
    logic [IDX_BITS-1:0] start_ptr_q;

    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            start_ptr_q <= '0;
        end else if (step_done) begin
            start_ptr_q <= (start_ptr_q == IDX_BITS'(ANT_NUM - 1)) ? '0 : start_ptr_q + 1'b1;
        end
    end

    assign start_ptr = start_ptr_q;
`else
    assign start_ptr = '0;
`endif

endmodule

// File: tb/tb_ant_step_scheduler.sv
// Directed bench for ant_step_scheduler with 4 ants and a 4-cycle settle wait.
module tb_ant_step_scheduler;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b0;
    logic        setup_mode = 1'b0;
    logic        step_req = 1'b0;
    logic [3:0]  alive_mask = 4'b1111;
    logic [31:0] ant_x;
    logic [27:0] ant_y;
    logic [3:0]  ant_sugar;
    logic        wr_ready = 1'b1;
    logic        new_loc_clk, global_writing_flag, wr_valid, wr_sugar, busy, step_done;
    logic [7:0]  wr_x;
    logic [6:0]  wr_y;
    logic [3:0]  move_now;
    logic [15:0] step_count;

    logic [7:0]  ax [4] = '{8'd11, 8'd33, 8'd80, 8'd100};
    logic [6:0]  ay [4] = '{7'd22, 7'd44, 7'd60, 7'd120};

    assign ant_x     = {ax[3], ax[2], ax[1], ax[0]};
    assign ant_y     = {ay[3], ay[2], ay[1], ay[0]};
    assign ant_sugar = 4'b0110;

    always #5 Clk = ~Clk;

    ant_step_scheduler #(
        .ANT_NUM       (4),
        .X_BITS        (8),
        .Y_BITS        (7),
        .SETTLE_CYCLES (4)
    ) dut (
        .Clk                 (Clk),
        .Reset_N             (Reset_N),
        .setup_mode          (setup_mode),
        .step_req            (step_req),
        .alive_mask          (alive_mask),
        .ant_x               (ant_x),
        .ant_y               (ant_y),
        .ant_sugar           (ant_sugar),
        .wr_ready            (wr_ready),
        .new_loc_clk         (new_loc_clk),
        .global_writing_flag (global_writing_flag),
        .wr_valid            (wr_valid),
        .wr_x                (wr_x),
        .wr_y                (wr_y),
        .wr_sugar            (wr_sugar),
        .move_now            (move_now),
        .busy                (busy),
        .step_done           (step_done),
        .step_count          (step_count)
    );

    int tests = 0;
    int fails = 0;

    logic [3:0] grants [$];
    logic [7:0] wxq [$];
    logic [6:0] wyq [$];
    logic       wsq [$];
    int nl_cyc, done_cyc, acc_cyc, mv1_cyc;
    int stall_cnt, unstable, stall_moves, multi, bad, wv_cnt, gwf_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset_N = 1'b0;
        tick();
        tick();
        Reset_N = 1'b1;
    endtask

    function automatic logic [31:0] out_vec();
        return {7'd0, new_loc_clk, global_writing_flag, wr_valid, wr_x, wr_y, wr_sugar,
                move_now, busy, step_done};
    endfunction

    // One step; cycle 0 is the request cycle. Records what the DUT did for later checks.
    task automatic run_step(input int stall, input int extra_req, input bit req_at_done);
        int  cyc;
        int  stall_left;
        bit  seen_w;
        logic [7:0] fx;
        logic [6:0] fy;
        grants.delete(); wxq.delete(); wyq.delete(); wsq.delete();
        nl_cyc = -1; done_cyc = -1; acc_cyc = -1; mv1_cyc = -1;
        stall_cnt = 0; unstable = 0; stall_moves = 0; multi = 0; bad = 0; wv_cnt = 0; gwf_cnt = 0;
        stall_left = stall;
        seen_w = 1'b0;
        fx = '0;
        fy = '0;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        cyc = 1;
        while (done_cyc < 0 && cyc < 200) begin
            step_req = (cyc == extra_req);
            if (wr_valid && !seen_w) begin
                seen_w = 1'b1;
                fx = wr_x;
                fy = wr_y;
            end
            if (wr_valid && stall_left > 0) begin
                wr_ready = 1'b0;
                stall_left--;
                stall_cnt++;
                if (wr_x !== fx || wr_y !== fy) unstable++;
            end else begin
                wr_ready = 1'b1;
            end
            if (seen_w && acc_cyc < 0 && move_now != 4'b0) stall_moves++;
            if (wr_valid && wr_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                wxq.push_back(wr_x);
                wyq.push_back(wr_y);
                wsq.push_back(wr_sugar);
            end
            if (move_now != 4'b0) begin
                grants.push_back(move_now);
                if (mv1_cyc < 0) mv1_cyc = cyc;
            end
            if ($countones(move_now) > 1) multi++;
            if ((move_now != 4'b0 || wr_valid) && !global_writing_flag) bad++;
            if (wr_valid) wv_cnt++;
            if (global_writing_flag) gwf_cnt++;
            if (new_loc_clk && nl_cyc < 0) nl_cyc = cyc;
            if (step_done) begin
                done_cyc = cyc;
                if (req_at_done) step_req = 1'b1;
            end
            tick();
            cyc++;
        end
        step_req = 1'b0;
        wr_ready = 1'b1;
    endtask

    function automatic logic [3:0] grant_at(input int i);
        return (i < grants.size()) ? grants[i] : 4'bxxxx;
    endfunction

    initial begin
        int busy_cnt;
        int done_cnt;
        int acc;
        bit found;
        logic [3:0] exp_first;

        // reset state
        Reset_N = 1'b0;
        tick(); tick(); tick();
        check_eq("reset_outputs", out_vec(), 32'd0);
        check_eq("reset_count", 32'(step_count), 32'd0);
        Reset_N = 1'b1;
        tick();

        // all four alive; a request mid-step and one on step_done are both ignored
        alive_mask = 4'b1111;
        run_step(0, 5, 1'b1);
        check_eq("t1_new_loc_cyc", nl_cyc, 1);
        check_eq("t1_grant_cnt", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t1_grant%0d", i), 32'(grant_at(i)), 32'(4'b0001 << i));
            check_eq($sformatf("t1_wr%0d", i),
                     (i < wxq.size()) ? {17'd0, wsq[i], wyq[i], wxq[i]} : 32'hxxxx_xxxx,
                     {17'd0, ant_sugar[i], ay[i], ax[i]});
        end
        check_eq("t1_latency", done_cyc + 1, 1 + 1 + 4 + 2 * 4 + 1);
        check_eq("t1_count", 32'(step_count), 32'd1);
        check_eq("t1_multi_hot", multi, 0);
        check_eq("t1_flag_cover", bad, 0);
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) busy_cnt++;
            tick();
        end
        check_eq("t1_no_extra_step", busy_cnt, 0);
        check_eq("t1_count_after", 32'(step_count), 32'd1);

        // sparse mask: ants 0 and 2 only
        apply_reset();
        alive_mask = 4'b0101;
        run_step(0, -1, 1'b0);
        check_eq("t2_grant_cnt", grants.size(), 2);
        check_eq("t2_grant0", 32'(grant_at(0)), 32'h1);
        check_eq("t2_grant1", 32'(grant_at(1)), 32'h4);
        check_eq("t2_wr1", (wxq.size() > 1) ? {17'd0, wsq[1], wyq[1], wxq[1]} : 32'hxxxx_xxxx,
                 {17'd0, 1'b1, 7'd60, 8'd80});
        check_eq("t2_no_odd_ants", 32'(grant_at(0) | grant_at(1)) & 32'hA, 32'd0);
        check_eq("t2_count", 32'(step_count), 32'd1);

        // ten-cycle backpressure on the first write
        apply_reset();
        alive_mask = 4'b1111;
        run_step(10, -1, 1'b0);
        check_eq("t3_stall_cycles", stall_cnt, 10);
        check_eq("t3_addr_stable", unstable, 0);
        check_eq("t3_no_early_move", stall_moves, 0);
        check_eq("t3_move_after_accept", mv1_cyc - acc_cyc, 1);
        check_eq("t3_first_grant", 32'(grant_at(0)), 32'h1);
        check_eq("t3_latency", done_cyc + 1, 15 + 10);

        // nobody alive
        alive_mask = 4'b0000;
        run_step(0, -1, 1'b0);
        check_eq("t4_new_loc_cyc", nl_cyc, 1);
        check_eq("t4_wr_valid_cnt", wv_cnt, 0);
        check_eq("t4_flag_cnt", gwf_cnt, 0);
        check_eq("t4_done_cyc", done_cyc, 6);
        check_eq("t4_count", 32'(step_count), 32'd2);

        // setup_mode during the second grant
        apply_reset();
        alive_mask = 4'b1111;
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        acc = 0;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (wr_valid && acc == 1) begin
                found = 1'b1;
            end else begin
                if (wr_valid && wr_ready) acc++;
                tick();
            end
        end
        check_eq("t5_reached_grant2", 32'(found), 32'd1);
        setup_mode = 1'b1;
        tick();
        check_eq("t5_abort_outputs", out_vec(), 32'd0);
        setup_mode = 1'b0;
        done_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (step_done) done_cnt++;
            if (busy) busy_cnt++;
            tick();
        end
        check_eq("t5_no_done", done_cnt + busy_cnt, 0);
        check_eq("t5_count", 32'(step_count), 32'd0);

        // reset during SETTLE after one completed step
        run_step(0, -1, 1'b0);
        check_eq("t6_count_pre", 32'(step_count), 32'd1);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        tick();
        tick();
        Reset_N = 1'b0;
        tick();
        check_eq("t6_reset_outputs", out_vec(), 32'd0);
        check_eq("t6_reset_count", 32'(step_count), 32'd0);
        Reset_N = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (step_done || busy) done_cnt++;
            tick();
        end
        check_eq("t6_no_done", done_cnt, 0);

        // first-write priority over three consecutive steps
        for (int k = 0; k < 3; k++) begin
`ifdef ANT_SCHED_ROTATE_EN
            exp_first = 4'b0001 << k;
`else
            exp_first = 4'b0001;
`endif
            run_step(0, -1, 1'b0);
            check_eq($sformatf("t7_first_grant%0d", k), 32'(grant_at(0)), 32'(exp_first));
            check_eq($sformatf("t7_grant_cnt%0d", k), grants.size(), 4);
        end
        check_eq("t7_count", 32'(step_count), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
